// File: rtl/cpu_arb_pkg.sv
// Shared encodings and constants for the unified instruction/data memory arbiter.
// Imported by unified_mem_arbiter and arb_watchdog.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } arb_gnt_e;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;

    // Memory is word-addressed on the bus side; byte offset bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return byte_addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// BUSY-phase timeout counter: restarts on start, stops on ack or expiry.
// Only instantiated when UNIFIED_MEM_ARB_TIMEOUT_EN is defined.
module arb_watchdog
    import cpu_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic             run_r;
    logic [CNT_W-1:0] cnt_r;

    // cnt_r holds the number of completed BUSY cycles; expiry fires in the TIMEOUT-th one.
    assign expire = run_r & (cnt_r == LAST);

    // Run/count state: cleared on every new grant so each access gets a full window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (start) begin
            run_r <= 1'b1;
            cnt_r <= {CNT_W{1'b0}};
        end else if (run_r && (ack || expire)) begin
            run_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (run_r) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF and MEM stage access to one single-port unified memory.
// Optional BUSY timeout/abort enabled by defining UNIFIED_MEM_ARB_TIMEOUT_EN.
module unified_mem_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int MAX_D_GRANTS = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_inst,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int CNT_W = $clog2(MAX_D_GRANTS + 1);
    localparam logic [CNT_W-1:0] D_LIMIT = CNT_W'(MAX_D_GRANTS);

    arb_state_e       state_r;
    arb_gnt_e         gnt_r;
    logic [CNT_W-1:0] dcnt_r;
    logic             grant_s;
    logic             win_if_s;
    logic             expire_s;
    logic [31:0]      rsp_data_s;

    // Data has priority unless it has already taken MAX_D_GRANTS in a row past a waiting fetch.
    assign grant_s    = (state_r == IDLE) & (if_req | d_req);
    assign win_if_s   = if_req & (~d_req | (dcnt_r == D_LIMIT));
    assign rsp_data_s = mem_ack ? mem_rdata : ARB_ABORT_DATA;

    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;

`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (grant_s),
        .ack    (mem_ack),
        .expire (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // Arbitration FSM with all handshake and response outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            gnt_r     <= GNT_IF;
            dcnt_r    <= {CNT_W{1'b0}};
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            if_inst   <= 32'h0;
            d_rdata   <= 32'h0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    if (grant_s) begin
                        state_r <= BUSY;
                        mem_req <= 1'b1;
                        if (win_if_s) begin
                            gnt_r     <= GNT_IF;
                            mem_addr  <= word_align(if_addr);
                            mem_we    <= 1'b0;
                            mem_wdata <= 32'h0;
                            dcnt_r    <= {CNT_W{1'b0}};
                        end else begin
                            gnt_r     <= GNT_D;
                            mem_addr  <= word_align(d_addr);
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            if (if_req) begin
                                dcnt_r <= dcnt_r + CNT_W'(1);
                            end else begin
                                dcnt_r <= {CNT_W{1'b0}};
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // A real ack always beats a same-cycle expiry.
                    if (mem_ack || expire_s) begin
                        state_r <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_ack) begin
                            err <= 1'b1;
                        end
                        if (gnt_r == GNT_IF) begin
                            if_inst  <= rsp_data_s;
                            if_ready <= 1'b1;
                        end else begin
                            d_ready <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= rsp_data_s;
                            end
                        end
                    end else begin
                        state_r <= BUSY;
                    end
                end
                RESP: begin
                    state_r  <= IDLE;
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (MAX_D_GRANTS=4, TIMEOUT=8).
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    int checks;
    int failures;

    unified_mem_arbiter #(
        .MAX_D_GRANTS (4),
        .TIMEOUT      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_inst   (if_inst),
        .if_ready  (if_ready),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, if_ready, d_ready, err, if_stall, d_stall} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {mem_req, mem_we, if_ready, d_ready, err, if_stall, d_stall});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_inst, d_rdata} !== 128'h0) begin
            failures++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0",
                     mem_addr, mem_wdata, if_inst, d_rdata);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1;
        if_addr = 32'h0000_0010;
        #1;
        checks++;
        if (if_stall !== 1'b1) begin
            failures++; $display("FAIL fetch_stall_idle: got %b expected 1", if_stall);
        end
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            failures++;
            $display("FAIL fetch_busy: got req=%b we=%b addr=%h expected 1 0 00000010", mem_req, mem_we, mem_addr);
        end
        checks++;
        if ({if_stall, if_ready} !== 2'b10) begin
            failures++; $display("FAIL fetch_stall_busy: got %b expected 10", {if_stall, if_ready});
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h2008_0005;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({if_ready, if_stall, mem_req, if_inst} !== {3'b100, 32'h2008_0005}) begin
            failures++;
            $display("FAIL fetch_resp: got ready=%b stall=%b req=%b inst=%h expected 1 0 0 20080005",
                     if_ready, if_stall, mem_req, if_inst);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if ({if_ready, mem_req} !== 2'b00) begin
            failures++; $display("FAIL fetch_pulse_end: got %b expected 00", {if_ready, mem_req});
        end
    endtask

    task automatic test_simultaneous();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0103;
        if_req = 1'b1; if_addr = 32'h0000_0020;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, if_stall, d_stall} !== {2'b10, 32'h100, 2'b11}) begin
            failures++;
            $display("FAIL simul_d_busy: got req=%b we=%b addr=%h istall=%b dstall=%b expected 1 0 00000100 1 1",
                     mem_req, mem_we, mem_addr, if_stall, d_stall);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({d_ready, d_stall, if_stall, if_ready, d_rdata} !== {4'b1010, 32'h1111_2222}) begin
            failures++;
            $display("FAIL simul_d_resp: got dready=%b dstall=%b istall=%b iready=%b rdata=%h expected 1 0 1 0 11112222",
                     d_ready, d_stall, if_stall, if_ready, d_rdata);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if ({mem_req, if_stall} !== 2'b01) begin
            failures++; $display("FAIL simul_idle: got req=%b istall=%b expected 0 1", mem_req, if_stall);
        end
        tick();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h20}) begin
            failures++; $display("FAIL simul_if_busy: got req=%b addr=%h expected 1 00000020", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h3333_4444;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({if_ready, if_inst} !== {1'b1, 32'h3333_4444}) begin
            failures++; $display("FAIL simul_if_resp: got ready=%b inst=%h expected 1 33334444", if_ready, if_inst);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic        exp_if;
        logic [31:0] exp_addr;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
        if_req = 1'b1; if_addr = 32'h0000_0300;
        for (int i = 0; i < 10; i++) begin
            exp_if = ((i % 5) == 4);
            exp_addr = exp_if ? 32'h0000_0300 : 32'h0000_0200;
            tick();
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, exp_addr}) begin
                failures++;
                $display("FAIL starve_grant%0d: got req=%b addr=%h expected 1 %h", i, mem_req, mem_addr, exp_addr);
            end
            mem_ack = 1'b1;
            mem_rdata = 32'h5000_0000 + 32'(i);
            tick();
            mem_ack = 1'b0;
            checks++;
            if ({if_ready, d_ready} !== (exp_if ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL starve_ready%0d: got if/d=%b expected %b", i, {if_ready, d_ready},
                         (exp_if ? 2'b10 : 2'b01));
            end
            tick();
        end
        d_req = 1'b0;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_wdata = 32'hCAFE_F00D; d_addr = 32'h0000_0040;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL store_busy: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000040 cafef00d",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({d_ready, d_rdata} !== {1'b1, 32'h5000_0008}) begin
            failures++; $display("FAIL store_resp: got ready=%b rdata=%h expected 1 50000008", d_ready, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        checks++;
        if ({d_ready, mem_req} !== 2'b00) begin
            failures++; $display("FAIL store_pulse_end: got %b expected 00", {d_ready, mem_req});
        end
    endtask

    task automatic test_reset_mid_busy();
        if_req = 1'b1; if_addr = 32'h0000_0080;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++; $display("FAIL rstmid_busy: got req=%b expected 1", mem_req);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, if_ready, d_ready, err, mem_addr, if_inst, d_rdata} !== {5'b0, 96'h0}) begin
            failures++;
            $display("FAIL rstmid_async: got req=%b addr=%h inst=%h rdata=%h expected all 0",
                     mem_req, mem_addr, if_inst, d_rdata);
        end
        if_req = 1'b0;
        tick();
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({if_ready, d_ready, mem_req, if_inst, d_rdata} !== {3'b000, 64'h0}) begin
            failures++;
            $display("FAIL late_ack: got iready=%b dready=%b req=%b inst=%h rdata=%h expected 0 0 0 0 0",
                     if_ready, d_ready, mem_req, if_inst, d_rdata);
        end
    endtask

    task automatic test_timeout();
        if_req = 1'b1; if_addr = 32'h0000_0090;
        tick();
`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
        for (int k = 2; k <= 8; k++) begin
            tick();
            checks++;
            if ({mem_req, if_ready, err} !== 3'b100) begin
                failures++;
                $display("FAIL timeout_wait%0d: got req/ready/err=%b expected 100", k, {mem_req, if_ready, err});
            end
        end
        tick();
        checks++;
        if ({if_ready, mem_req, err, if_inst} !== {3'b101, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL timeout_abort: got ready=%b req=%b err=%b inst=%h expected 1 0 1 deadbeef",
                     if_ready, mem_req, err, if_inst);
        end
        if_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({err, if_ready} !== 2'b10) begin
            failures++; $display("FAIL timeout_sticky: got err/ready=%b expected 10", {err, if_ready});
        end
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if ({mem_req, if_ready, err} !== 3'b100) begin
                failures++;
                $display("FAIL notimeout_wait%0d: got req/ready/err=%b expected 100", k, {mem_req, if_ready, err});
            end
        end
        if_req = 1'b0;
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({err, mem_req, if_ready} !== 3'b000) begin
            failures++; $display("FAIL timeout_cleared: got err/req/ready=%b expected 000", {err, mem_req, if_ready});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        test_reset();
        test_fetch();
        test_simultaneous();
        test_back_to_back();
        test_store();
        test_reset_mid_busy();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
